regfile_context_engine: RTL and testbench

//  Initiator-side engine for the 32x32 register file ports: drives read_reg/write_reg/write_data/reg_write.

---
 rtl/regfile_context_engine_pkg.sv | 18 +
 rtl/regfile_context_engine.sv | 151 +++++++++++++++
 tb/tb_regfile_context_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_context_engine_pkg.sv
// Shared definitions for the register file context engine.
//   state_e  : FSM state encoding
//   REG_ZERO : index of the hardwired-zero register
package regfile_context_engine_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE    = 3'd0,
        S_READ  = 3'd1,
        S_SEND  = 3'd2,
        R_WRITE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_context_engine.sv
// Register file context engine: SAVE streams registers FIRST_REG..LAST_REG out over
// a valid/ready port; RESTORE writes an incoming valid/ready stream back in the same order.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   save_start, restore_start    start pulses, sampled only in IDLE (SAVE wins a tie)
//   busy, done                   engine active / one-cycle completion pulse
//   rf_read_reg, rf_read_data    register file read port (read data combinational)
//   rf_write_reg, rf_write_data,
//   rf_reg_write                 register file write port
//   out_valid, out_ready,
//   out_index, out_data          SAVE stream (registered payload)
//   in_valid, in_ready, in_data  RESTORE stream
module regfile_context_engine
    import regfile_context_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIRST_REG  = 1,
    parameter int unsigned LAST_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  save_start,
    input  logic                  restore_start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_read_reg,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [ADDR_WIDTH-1:0] rf_write_reg,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;
    logic                    r_out_valid;
    logic                    w_out_valid_nxt;
    logic [ADDR_WIDTH-1:0]   r_out_index;
    logic [ADDR_WIDTH-1:0]   w_out_index_nxt;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [DATA_WIDTH-1:0]   w_out_data_nxt;
    logic                    w_last;
    logic                    w_rf_reg_write;
    logic [ADDR_WIDTH-1:0]   w_rf_write_reg;
    logic [DATA_WIDTH-1:0]   w_rf_write_data;
    logic                    w_in_ready;

    // Exact terminal compare: the index never wraps past LAST_REG.
    assign w_last = (r_idx == ADDR_WIDTH'(LAST_REG));

    // State, index and SAVE output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= ADDR_WIDTH'(FIRST_REG);
            r_out_valid <= 1'b0;
            r_out_index <= ADDR_WIDTH'(REG_ZERO);
            r_out_data  <= DATA_WIDTH'(0);
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    // Next-state, next-datapath and combinational write-port/ready logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;
        w_out_index_nxt = r_out_index;
        w_out_data_nxt  = r_out_data;
        w_rf_reg_write  = 1'b0;
        w_rf_write_reg  = ADDR_WIDTH'(REG_ZERO);
        w_rf_write_data = DATA_WIDTH'(0);
        w_in_ready      = 1'b0;

        case (r_state)
            IDLE: begin
                if (save_start) begin
                    w_state_nxt = S_READ;
                    w_idx_nxt   = ADDR_WIDTH'(FIRST_REG);
                end else if (restore_start) begin
                    w_state_nxt = R_WRITE;
                    w_idx_nxt   = ADDR_WIDTH'(FIRST_REG);
                end
            end
            S_READ: begin
                w_out_data_nxt  = rf_read_data;
                w_out_index_nxt = r_idx;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_SEND;
            end
            S_SEND: begin
                // out_valid is always high here, so out_ready alone completes the beat.
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
                        w_state_nxt = S_READ;
                    end
                end
            end
            R_WRITE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_rf_reg_write  = 1'b1;
                    w_rf_write_reg  = r_idx;
                    w_rf_write_data = in_data;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status and write-port outputs decode from the state register, so reset clears them at once.
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign in_ready      = w_in_ready;
    assign rf_reg_write  = w_rf_reg_write;
    assign rf_write_reg  = w_rf_write_reg;
    assign rf_write_data = w_rf_write_data;
    assign rf_read_reg   = (r_state == IDLE) ? ADDR_WIDTH'(REG_ZERO) : r_idx;
    assign out_valid     = r_out_valid;
    assign out_index     = r_out_index;
    assign out_data      = r_out_data;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Directed bench: two engines (full range and single register 7), each beside a
// behavioural register file whose write port is muxed between engine and bench by busy.
module tb_regfile_context_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Shared bench write path used for preloading.
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [31:0] tb_wd;

    // Engine A: FIRST_REG=1, LAST_REG=31.
    logic        save_a, restore_a, busy_a, done_a;
    logic [4:0]  rd_reg_a, wr_reg_a, out_index_a;
    logic [31:0] rd_data_a, wr_data_a, out_data_a, in_data_a;
    logic        reg_write_a, out_valid_a, ready_a, in_valid_a, in_ready_a;
    logic [31:0] rf_a [32];

    // Engine B: FIRST_REG=LAST_REG=7.
    logic        save_b, restore_b, busy_b, done_b;
    logic [4:0]  rd_reg_b, wr_reg_b, out_index_b;
    logic [31:0] rd_data_b, wr_data_b, out_data_b, in_data_b;
    logic        reg_write_b, out_valid_b, ready_b, in_valid_b, in_ready_b;
    logic [31:0] rf_b [32];

    regfile_context_engine u_dut_a (
        .clk(clk), .reset(reset), .save_start(save_a), .restore_start(restore_a),
        .busy(busy_a), .done(done_a), .rf_read_reg(rd_reg_a), .rf_read_data(rd_data_a),
        .rf_write_reg(wr_reg_a), .rf_write_data(wr_data_a), .rf_reg_write(reg_write_a),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_index(out_index_a), .out_data(out_data_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a)
    );

    regfile_context_engine #(.FIRST_REG(7), .LAST_REG(7)) u_dut_b (
        .clk(clk), .reset(reset), .save_start(save_b), .restore_start(restore_b),
        .busy(busy_b), .done(done_b), .rf_read_reg(rd_reg_b), .rf_read_data(rd_data_b),
        .rf_write_reg(wr_reg_b), .rf_write_data(wr_data_b), .rf_reg_write(reg_write_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_index(out_index_b), .out_data(out_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b)
    );

    // Register file models: combinational read, write on posedge through the busy-selected mux.
    assign rd_data_a = rf_a[rd_reg_a];
    assign rd_data_b = rf_b[rd_reg_b];

    always @(posedge clk) begin
        if (busy_a ? reg_write_a : tb_we) rf_a[busy_a ? wr_reg_a : tb_wa] <= busy_a ? wr_data_a : tb_wd;
        if (busy_b ? reg_write_b : tb_we) rf_b[busy_b ? wr_reg_b : tb_wa] <= busy_b ? wr_data_b : tb_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes r0=0 and rN=base+N (N=1..31) into both register files.
    task automatic preload(input logic [31:0] base);
        for (int n = 0; n < 32; n++) begin
            tb_we = 1'b1;
            tb_wa = 5'(n);
            tb_wd = (n == 0) ? 32'd0 : base + 32'(n);
            tick();
        end
        tb_we = 1'b0;
    endtask

    // SAVE on engine A; optional 1-of-3 ready throttle, simultaneous restore_start, mid-run restore_start.
    task automatic run_save(input bit throttle, input bit both_start, input bit mid_restore);
        int          exp_i = 1;
        int          beats = 0;
        int          dones = 0;
        int          writes = 0;
        bit          stalled = 1'b0;
        bit          fin = 1'b0;
        logic [31:0] hold_d = '0;
        logic [4:0]  hold_i = '0;
        save_a    = 1'b1;
        restore_a = both_start;
        tick();
        save_a    = 1'b0;
        restore_a = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            ready_a   = throttle ? (cyc % 3 == 2) : 1'b1;
            restore_a = mid_restore && (cyc == 20);
            #1;
            if (stalled) begin
                chk("save_hold_data", out_data_a, hold_d);
                chk("save_hold_index", 32'(out_index_a), 32'(hold_i));
            end
            stalled = out_valid_a && !ready_a;
            hold_d  = out_data_a;
            hold_i  = out_index_a;
            if (reg_write_a) writes++;
            if (out_valid_a && ready_a) begin
                chk("save_index", 32'(out_index_a), 32'(exp_i));
                chk("save_data", out_data_a, 32'hA000_0000 + 32'(exp_i));
                exp_i++;
                beats++;
            end
            if (done_a) begin
                dones++;
            end else if (dones > 0) begin
                chk("save_busy_after_done", 32'(busy_a), 32'd0);
                fin = 1'b1;
            end
            tick();
        end
        ready_a   = 1'b0;
        restore_a = 1'b0;
        chk("save_finished", 32'(fin), 32'd1);
        chk("save_beats", 32'(beats), 32'd31);
        chk("save_done_pulses", 32'(dones), 32'd1);
        if (both_start || mid_restore) chk("save_no_rf_write", 32'(writes), 32'd0);
    endtask

    // RESTORE on engine A with in_data=5000_0000+N; abort_after>0 asserts reset after that many beats.
    task automatic run_restore(input int abort_after);
        int k = 1;
        int writes = 0;
        int dones = 0;
        bit fin = 1'b0;
        restore_a = 1'b1;
        tick();
        restore_a = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            in_valid_a = 1'b1;
            in_data_a  = 32'h5000_0000 + 32'(k);
            #1;
            if (abort_after != 0 && k > abort_after) begin
                reset = 1'b1;
                #1;
                chk("abort_rf_write_low", 32'(reg_write_a), 32'd0);
                chk("abort_busy_low", 32'(busy_a), 32'd0);
                chk("abort_no_done", 32'(done_a), 32'd0);
                fin = 1'b1;
            end else begin
                if (busy_a && !done_a) chk("restore_write_every_cycle", 32'(reg_write_a), 32'd1);
                if (reg_write_a) begin
                    chk("restore_wr_index", 32'(wr_reg_a), 32'(k));
                    chk("restore_wr_data", wr_data_a, 32'h5000_0000 + 32'(k));
                    k++;
                    writes++;
                end
                if (done_a) begin
                    dones++;
                end else if (dones > 0) begin
                    chk("restore_busy_after_done", 32'(busy_a), 32'd0);
                    fin = 1'b1;
                end
            end
            tick();
        end
        in_valid_a = 1'b0;
        chk("restore_finished", 32'(fin), 32'd1);
        if (abort_after != 0) begin
            for (int c = 0; c < 2; c++) begin
                if (done_a) dones++;
                tick();
            end
            reset = 1'b0;
            tick();
            chk("abort_busy_after_release", 32'(busy_a), 32'd0);
            chk("abort_writes", 32'(writes), 32'(abort_after));
            chk("abort_done_pulses", 32'(dones), 32'd0);
        end else begin
            chk("restore_writes", 32'(writes), 32'd31);
            chk("restore_done_pulses", 32'(dones), 32'd1);
        end
    endtask

    initial begin
        int beats;
        int dones;
        int writes;
        bit fin;
        reset = 1'b1;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        save_a = 1'b0; restore_a = 1'b0; ready_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
        save_b = 1'b0; restore_b = 1'b0; ready_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_index", 32'(out_index_a), 32'd0);
        chk("rst_out_data", out_data_a, 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_rf_reg_write", 32'(reg_write_a), 32'd0);
        chk("rst_rf_write_reg", 32'(wr_reg_a), 32'd0);
        chk("rst_rf_write_data", wr_data_a, 32'd0);
        chk("rst_rf_read_reg", 32'(rd_reg_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        preload(32'hA000_0000);
        run_save(1'b0, 1'b0, 1'b0);   // full-rate SAVE
        run_save(1'b1, 1'b0, 1'b0);   // throttled SAVE
        run_save(1'b0, 1'b1, 1'b1);   // start tie and mid-SAVE restore_start

        run_restore(0);
        for (int n = 0; n < 32; n++)
            chk("restore_readback", rf_a[n], (n == 0) ? 32'd0 : 32'h5000_0000 + 32'(n));

        preload(32'hA000_0000);
        run_restore(10);
        for (int n = 0; n < 32; n++)
            chk("abort_readback", rf_a[n],
                (n == 0) ? 32'd0 : (n <= 10) ? 32'h5000_0000 + 32'(n) : 32'hA000_0000 + 32'(n));

        // Single-register engine: SAVE of r7.
        beats = 0; dones = 0; fin = 1'b0;
        save_b = 1'b1;
        tick();
        save_b  = 1'b0;
        ready_b = 1'b1;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            #1;
            if (out_valid_b) begin
                chk("single_save_index", 32'(out_index_b), 32'd7);
                chk("single_save_data", out_data_b, 32'hA000_0007);
                beats++;
            end
            if (done_b) begin
                dones++;
            end else if (dones > 0) begin
                chk("single_save_busy_after_done", 32'(busy_b), 32'd0);
                fin = 1'b1;
            end
            tick();
        end
        ready_b = 1'b0;
        chk("single_save_beats", 32'(beats), 32'd1);
        chk("single_save_done_pulses", 32'(dones), 32'd1);

        // Single-register engine: RESTORE of r7.
        writes = 0; dones = 0; fin = 1'b0;
        restore_b = 1'b1;
        tick();
        restore_b  = 1'b0;
        in_valid_b = 1'b1;
        in_data_b  = 32'h7777_0007;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            #1;
            if (reg_write_b) begin
                chk("single_restore_index", 32'(wr_reg_b), 32'd7);
                writes++;
            end
            if (done_b) begin
                dones++;
            end else if (dones > 0) begin
                fin = 1'b1;
            end
            tick();
        end
        in_valid_b = 1'b0;
        chk("single_restore_writes", 32'(writes), 32'd1);
        chk("single_restore_done_pulses", 32'(dones), 32'd1);
        chk("single_restore_r7", rf_b[7], 32'h7777_0007);
        chk("single_restore_r6", rf_b[6], 32'hA000_0006);
        chk("single_restore_r8", rf_b[8], 32'hA000_0008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
